dla_flit_packetizer: RTL and testbench
======================================

DLA_FLIT_PACKETIZER -- requirements
Module: dla_flit_packetizer

Interface
REQ-001 Parameter LEN_W, default 8, width of payload-length field.
REQ-002 Parameter CNT_W, default 16, width of packet counter.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_vld  in  1  DLA data-packet request valid.
REQ-006 req_rdy  out  1  data-packet request accepted.
REQ-007 req_dest_x/req_dest_y/req_dest_l  in  DEST_ADDR_SIZE_X/Y/L  packet destination.
REQ-008 req_len  in  LEN_W  payload word count N; 0 is treated as 1.
REQ-009 pl_vld  in  1 / pl_rdy  out  1 / pl_data  in  FLIT_DATA_SIZE  payload stream, valid/ready.
REQ-010 grnt_req_vld  in  1 / grnt_req_rdy  out  1  grant-packet request handshake.
REQ-011 grnt_dest_x/y/l  in  DEST_ADDR_SIZE_X/Y/L  grant-packet destination.
REQ-012 grnt_x  in  DEST_ADDR_SIZE_X / grnt_y  in  DEST_ADDR_SIZE_Y / grnt_dla  in  2  granted requester id.
REQ-013 buf_full  in  1 / buf_afull  in  1  router read-buffer FIFO status; afull = at most one free entry.
REQ-014 buf_wen  out  1 / buf_wdata  out  FLIT_TOTAL_SIZE  FIFO write port.
REQ-015 pkt_cnt  out  CNT_W  count of TAIL and HEADTAIL flits written.

Function
REQ-016 slot_ok = !buf_full && !buf_afull; no handshake completes unless slot_ok.
REQ-017 buf_wen and buf_wdata are registered; each completed handshake produces exactly one write on the next cycle; otherwise buf_wen = 0.
REQ-018 Flit format: label in [FLIT_TOTAL_SIZE-1:FLIT_DATA_SIZE]; data in [FLIT_DATA_SIZE-1:0].
REQ-019 HEAD/HEADTAIL data: dest_l at [0 +: L], dest_y at [L +: Y], dest_x at [L+Y +: X], head_pl at [L+Y+X +: X+Y+2]; remaining bits 0.
REQ-020 HEADTAIL head_pl = {grnt_x, grnt_y, grnt_dla}, grnt_dla in bits [1:0]; HEAD head_pl = 0.
REQ-021 BODY/TAIL data = pl_data unmodified.
REQ-022 FSM states: IDLE and PAYLOAD; 1-bit state register.
REQ-023 IDLE: grnt_req_rdy = slot_ok; on grant handshake, write HEADTAIL; remain in IDLE.
REQ-024 IDLE: req_rdy = slot_ok && !grnt_req_vld; grant requests have strict priority.
REQ-025 On data-request handshake: write HEAD; load remaining counter with max(req_len,1); go to PAYLOAD.
REQ-026 PAYLOAD: pl_rdy = slot_ok; req_rdy = grnt_req_rdy = 0; grant requests wait until the packet ends.
REQ-027 PAYLOAD payload handshake: write BODY if remaining > 1, else TAIL; decrement remaining.
REQ-028 After TAIL is written, return to IDLE.
REQ-029 pl_rdy = 0 in IDLE.
REQ-030 Sustained throughput: one flit per cycle while slot_ok holds.
REQ-031 A packet of N payload words produces N+1 flits.
REQ-032 pkt_cnt increments by 1 per TAIL/HEADTAIL write and wraps modulo 2^CNT_W.
REQ-033 buf_afull rising mid-packet stalls the packet; no flit is dropped or duplicated.

Reset
REQ-034 Reset values: state=IDLE, remaining=0, buf_wen=0, buf_wdata=0, pkt_cnt=0; all ready outputs 0 during reset.
REQ-035 Reset mid-packet abandons the packet; no TAIL is generated. The downstream FIFO is reset by the same rst.

Structure
REQ-036 flit_label_t (HEAD, BODY, TAIL, HEADTAIL) and FLIT_DATA_SIZE, FLIT_TOTAL_SIZE, DEST_ADDR_SIZE_X/Y/L come from the shared global package/include; none are redefined locally.
REQ-037 One combinational sub-module, flit_head_encoder, builds HEAD/HEADTAIL data words from destination and head_pl.

Verification
REQ-038 Data req dest x=3,y=5,l=2, len=3, payload A1,A2,A3, FIFO empty -> HEAD(x3,y5,l2,pl=0), BODY A1, BODY A2, TAIL A3 on consecutive cycles; pkt_cnt=1.
REQ-039 Grant req x=1,y=2,dla=3, dest x=0,y=0,l=0 -> single HEADTAIL with head_pl={1,2,3}; pkt_cnt increments; FSM stays IDLE.
REQ-040 grnt_req_vld and req_vld asserted in the same cycle -> HEADTAIL written first, then HEAD on the next cycle.
REQ-041 buf_afull raised after BODY A1 of a len=4 packet for 5 cycles -> no writes during the stall; then BODY A2, A3 and TAIL A4, with no loss or duplication.
REQ-042 Payload with len=0 -> HEAD and TAIL only; a subsequent grant request is accepted only after the TAIL handshake.
REQ-043 rst asserted after BODY of a len=3 packet -> buf_wen=0 and state=IDLE immediately; a new request is then handled normally.

Source files
------------

// File: rtl/dla_flit_packetizer_pkg.sv
// dla_flit_packetizer_pkg: shared flit format, destination address widths and packetizer state type
package dla_flit_packetizer_pkg;
    localparam int FLIT_DATA_SIZE   = 32;
    localparam int FLIT_LABEL_SIZE  = 2;
    localparam int FLIT_TOTAL_SIZE  = FLIT_DATA_SIZE + FLIT_LABEL_SIZE;
    localparam int DEST_ADDR_SIZE_X = 4;
    localparam int DEST_ADDR_SIZE_Y = 4;
    localparam int DEST_ADDR_SIZE_L = 2;
    localparam int HEAD_PL_SIZE     = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + 2;
    typedef enum logic [FLIT_LABEL_SIZE-1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;
    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } pkt_state_t;
endpackage

// File: rtl/dla_flit_packetizer_if.sv
// dla_flit_packetizer_if: request, grant, payload and read-buffer write bundle of the packetizer
interface dla_flit_packetizer_if import dla_flit_packetizer_pkg::*; #(
    parameter int LEN_W = 8
);
    logic                        req_vld;
    logic                        req_rdy;
    logic [DEST_ADDR_SIZE_X-1:0] req_dest_x;
    logic [DEST_ADDR_SIZE_Y-1:0] req_dest_y;
    logic [DEST_ADDR_SIZE_L-1:0] req_dest_l;
    logic [LEN_W-1:0]            req_len;
    logic                        pl_vld;
    logic                        pl_rdy;
    logic [FLIT_DATA_SIZE-1:0]   pl_data;
    logic                        grnt_req_vld;
    logic                        grnt_req_rdy;
    logic [DEST_ADDR_SIZE_X-1:0] grnt_dest_x;
    logic [DEST_ADDR_SIZE_Y-1:0] grnt_dest_y;
    logic [DEST_ADDR_SIZE_L-1:0] grnt_dest_l;
    logic [DEST_ADDR_SIZE_X-1:0] grnt_x;
    logic [DEST_ADDR_SIZE_Y-1:0] grnt_y;
    logic [1:0]                  grnt_dla;
    logic                        buf_full;
    logic                        buf_afull;
    logic                        buf_wen;
    logic [FLIT_TOTAL_SIZE-1:0]  buf_wdata;
    modport master (
        output req_vld, req_dest_x, req_dest_y, req_dest_l, req_len, pl_vld, pl_data,
               grnt_req_vld, grnt_dest_x, grnt_dest_y, grnt_dest_l, grnt_x, grnt_y, grnt_dla,
               buf_full, buf_afull,
        input  req_rdy, pl_rdy, grnt_req_rdy, buf_wen, buf_wdata
    );
    modport slave (
        input  req_vld, req_dest_x, req_dest_y, req_dest_l, req_len, pl_vld, pl_data,
               grnt_req_vld, grnt_dest_x, grnt_dest_y, grnt_dest_l, grnt_x, grnt_y, grnt_dla,
               buf_full, buf_afull,
        output req_rdy, pl_rdy, grnt_req_rdy, buf_wen, buf_wdata
    );
endinterface

// File: rtl/dla_flit_packetizer_flit_head_encoder.sv
// flit_head_encoder: packs destination and head payload into a HEAD/HEADTAIL data word
module flit_head_encoder import dla_flit_packetizer_pkg::*; (
    input  logic [DEST_ADDR_SIZE_X-1:0] dest_x,
    input  logic [DEST_ADDR_SIZE_Y-1:0] dest_y,
    input  logic [DEST_ADDR_SIZE_L-1:0] dest_l,
    input  logic [HEAD_PL_SIZE-1:0]     head_pl,
    output logic [FLIT_DATA_SIZE-1:0]   data
);
    localparam int Y_LO  = DEST_ADDR_SIZE_L;
    localparam int X_LO  = Y_LO + DEST_ADDR_SIZE_Y;
    localparam int PL_LO = X_LO + DEST_ADDR_SIZE_X;
    // fields packed from bit 0 upward, unused upper bits left zero
    always_comb begin
        data = '0;
        data[0 +: DEST_ADDR_SIZE_L]     = dest_l;
        data[Y_LO +: DEST_ADDR_SIZE_Y]  = dest_y;
        data[X_LO +: DEST_ADDR_SIZE_X]  = dest_x;
        data[PL_LO +: HEAD_PL_SIZE]     = head_pl;
    end
endmodule

// File: rtl/dla_flit_packetizer.sv
// dla_flit_packetizer: turns grant requests and data packets into flits for the router read buffer
module dla_flit_packetizer import dla_flit_packetizer_pkg::*; #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dla_flit_packetizer_if.slave bus,
    output logic [CNT_W-1:0]     pkt_cnt
);
    pkt_state_t                  state, state_nxt;
    logic [LEN_W-1:0]            remaining, remaining_nxt;
    logic                        slot_ok, grnt_hs, req_hs, pl_hs, last, wr;
    logic [DEST_ADDR_SIZE_X-1:0] dest_x;
    logic [DEST_ADDR_SIZE_Y-1:0] dest_y;
    logic [DEST_ADDR_SIZE_L-1:0] dest_l;
    logic [HEAD_PL_SIZE-1:0]     head_pl;
    logic [FLIT_DATA_SIZE-1:0]   head_data;
    flit_label_t                 label;
    logic [FLIT_TOTAL_SIZE-1:0]  flit;

    assign slot_ok = !bus.buf_full && !bus.buf_afull;

    flit_head_encoder u_enc (
        .dest_x  (dest_x),
        .dest_y  (dest_y),
        .dest_l  (dest_l),
        .head_pl (head_pl),
        .data    (head_data)
    );

    // packet state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // readiness with grant priority, flit selection and next state
    always_comb begin
        bus.grnt_req_rdy = !rst && state == IDLE && slot_ok;
        bus.req_rdy      = bus.grnt_req_rdy && !bus.grnt_req_vld;
        bus.pl_rdy       = !rst && state == PAYLOAD && slot_ok;
        grnt_hs          = bus.grnt_req_vld && bus.grnt_req_rdy;
        req_hs           = bus.req_vld && bus.req_rdy;
        pl_hs            = bus.pl_vld && bus.pl_rdy;
        last             = remaining <= LEN_W'(1);
        wr               = grnt_hs || req_hs || pl_hs;
        dest_x           = grnt_hs ? bus.grnt_dest_x : bus.req_dest_x;
        dest_y           = grnt_hs ? bus.grnt_dest_y : bus.req_dest_y;
        dest_l           = grnt_hs ? bus.grnt_dest_l : bus.req_dest_l;
        head_pl          = grnt_hs ? {bus.grnt_x, bus.grnt_y, bus.grnt_dla} : '0;
        label            = grnt_hs ? HEADTAIL : req_hs ? HEAD : last ? TAIL : BODY;
        flit             = {label, pl_hs ? bus.pl_data : head_data};
        state_nxt        = req_hs ? PAYLOAD : (pl_hs && last) ? IDLE : state;
        remaining_nxt    = req_hs ? ((bus.req_len == '0) ? LEN_W'(1) : bus.req_len)
                         : pl_hs  ? remaining - LEN_W'(1) : remaining;
    end

    // payload countdown, registered buffer write port and completed-packet counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining     <= '0;
            bus.buf_wen   <= 1'b0;
            bus.buf_wdata <= '0;
            pkt_cnt       <= '0;
        end else begin
            remaining   <= remaining_nxt;
            bus.buf_wen <= wr;
            if (wr) bus.buf_wdata <= flit;
            if (grnt_hs || (pl_hs && last)) pkt_cnt <= pkt_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dla_flit_packetizer.sv
// tb_dla_flit_packetizer: scoreboard bench with randomized packets, grants and buffer backpressure
module tb_dla_flit_packetizer;
    import dla_flit_packetizer_pkg::*;
    localparam int LEN_W = 8;
    localparam int CNT_W = 16;
    typedef logic [FLIT_TOTAL_SIZE-1:0] flit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CNT_W-1:0] pkt_cnt;
    logic bp_en = 1'b0;
    logic force_afull = 1'b0;
    logic rnd_full, rnd_afull;
    logic prev_slot = 1'b0;
    flit_t exp_q[$];
    int total = 0, bad = 0, exp_cnt = 0, cyc = 0;
    int head_cyc = 0, tail_cyc = 0, ht_cyc = 0;

    dla_flit_packetizer_if #(.LEN_W(LEN_W)) bus();

    dla_flit_packetizer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    assign bus.buf_full  = bp_en & rnd_full;
    assign bus.buf_afull = (bp_en & rnd_afull) | force_afull;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [FLIT_DATA_SIZE-1:0] head_word(input int dx, input int dy, input int dl, input int hp);
        return FLIT_DATA_SIZE'(dl + dy * (2 ** DEST_ADDR_SIZE_L)
                                  + dx * (2 ** (DEST_ADDR_SIZE_L + DEST_ADDR_SIZE_Y))
                                  + hp * (2 ** (DEST_ADDR_SIZE_L + DEST_ADDR_SIZE_Y + DEST_ADDR_SIZE_X)));
    endfunction

    function automatic int grant_pl(input int gx, input int gy, input int gd);
        return gx * (2 ** (DEST_ADDR_SIZE_Y + 2)) + gy * 4 + gd;
    endfunction

    // random buffer status, applied only while backpressure is enabled
    always @(posedge clk) begin
        #1;
        rnd_full  = ($urandom_range(0, 7) == 0);
        rnd_afull = ($urandom_range(0, 4) == 0);
    end

    // monitor: every buffer write is popped from the scoreboard and compared
    always @(negedge clk) begin
        flit_t e;
        cyc++;
        if (rst) exp_cnt = 0;
        else if (bus.buf_wen) begin
            check("slot_ok_before_write", prev_slot, 1'b1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h expected no write", bus.buf_wdata);
            end else begin
                e = exp_q.pop_front();
                check("flit", bus.buf_wdata, e);
                if (e[FLIT_TOTAL_SIZE-1:FLIT_DATA_SIZE] == HEAD) head_cyc = cyc;
                if (e[FLIT_TOTAL_SIZE-1:FLIT_DATA_SIZE] == TAIL) begin tail_cyc = cyc; exp_cnt++; end
                if (e[FLIT_TOTAL_SIZE-1:FLIT_DATA_SIZE] == HEADTAIL) begin ht_cyc = cyc; exp_cnt++; end
                check("pkt_cnt", pkt_cnt, CNT_W'(exp_cnt));
            end
        end
        prev_slot = !bus.buf_full && !bus.buf_afull;
    end

    task automatic wait_rdy(input int which, input string name);
        logic got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = (which == 0) ? bus.req_rdy : (which == 1) ? bus.grnt_req_rdy : bus.pl_rdy;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: ready got 0 expected 1 within 400 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_grant(input int gx, input int gy, input int gd, input int dx, input int dy, input int dl);
        bus.grnt_x      = DEST_ADDR_SIZE_X'(gx);
        bus.grnt_y      = DEST_ADDR_SIZE_Y'(gy);
        bus.grnt_dla    = 2'(gd);
        bus.grnt_dest_x = DEST_ADDR_SIZE_X'(dx);
        bus.grnt_dest_y = DEST_ADDR_SIZE_Y'(dy);
        bus.grnt_dest_l = DEST_ADDR_SIZE_L'(dl);
        exp_q.push_back({HEADTAIL, head_word(dx, dy, dl, grant_pl(gx, gy, gd))});
    endtask

    task automatic do_grant(input int gx, input int gy, input int gd, input int dx, input int dy, input int dl);
        set_grant(gx, gy, gd, dx, dy, dl);
        bus.grnt_req_vld = 1'b1;
        wait_rdy(1, "grant_handshake");
        bus.grnt_req_vld = 1'b0;
    endtask

    task automatic send_pkt(input int dx, input int dy, input int dl, input int len,
                            input bit gaps, input int stall_after, input bit fixed);
        int n = (len == 0) ? 1 : len;
        logic [FLIT_DATA_SIZE-1:0] w[$];
        flit_label_t lb;
        exp_q.push_back({HEAD, head_word(dx, dy, dl, 0)});
        for (int i = 0; i < n; i++) begin
            w.push_back(fixed ? FLIT_DATA_SIZE'(32'hA1 + i) : FLIT_DATA_SIZE'($urandom));
            lb = (i == n - 1) ? TAIL : BODY;
            exp_q.push_back({lb, w[i]});
        end
        bus.req_dest_x = DEST_ADDR_SIZE_X'(dx);
        bus.req_dest_y = DEST_ADDR_SIZE_Y'(dy);
        bus.req_dest_l = DEST_ADDR_SIZE_L'(dl);
        bus.req_len    = LEN_W'(len);
        bus.req_vld    = 1'b1;
        wait_rdy(0, "request_handshake");
        bus.req_vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            bus.pl_vld  = 1'b1;
            bus.pl_data = w[i];
            wait_rdy(2, "payload_handshake");
            bus.pl_vld = 1'b0;
            if (i == stall_after) begin
                force_afull = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check("pl_rdy_during_stall", bus.pl_rdy, 1'b0);
                end
                @(posedge clk);
                #1;
                force_afull = 1'b0;
            end
        end
    endtask

    initial begin
        bus.req_vld = 1'b0; bus.req_dest_x = '0; bus.req_dest_y = '0; bus.req_dest_l = '0; bus.req_len = '0;
        bus.pl_vld = 1'b0; bus.pl_data = '0;
        bus.grnt_req_vld = 1'b0; bus.grnt_dest_x = '0; bus.grnt_dest_y = '0; bus.grnt_dest_l = '0;
        bus.grnt_x = '0; bus.grnt_y = '0; bus.grnt_dla = '0;
        bus.grnt_req_vld = 1'b1;
        bus.req_vld = 1'b1;
        bus.pl_vld = 1'b1;
        #12;
        check("reset_buf_wen", bus.buf_wen, 1'b0);
        check("reset_buf_wdata", bus.buf_wdata, '0);
        check("reset_pkt_cnt", pkt_cnt, '0);
        check("reset_req_rdy", bus.req_rdy, 1'b0);
        check("reset_grnt_req_rdy", bus.grnt_req_rdy, 1'b0);
        check("reset_pl_rdy", bus.pl_rdy, 1'b0);
        bus.grnt_req_vld = 1'b0;
        bus.req_vld = 1'b0;
        bus.pl_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_pl_rdy", bus.pl_rdy, 1'b0);
        @(posedge clk);
        #1;

        send_pkt(3, 5, 2, 3, 1'b0, -1, 1'b1);
        drain();
        check("basic_pkt_span", tail_cyc - head_cyc, 3);
        check("basic_pkt_cnt", pkt_cnt, 1);

        do_grant(1, 2, 3, 0, 0, 0);
        drain();
        check("grant_pkt_cnt", pkt_cnt, 2);
        @(negedge clk);
        check("grant_stays_idle", bus.req_rdy, 1'b1);
        @(posedge clk);
        #1;

        set_grant(2, 1, 1, 1, 1, 1);
        exp_q.push_back({HEAD, head_word(4, 4, 3, 0)});
        exp_q.push_back({TAIL, FLIT_DATA_SIZE'(32'h5A5A0001)});
        bus.req_dest_x = 4'd4; bus.req_dest_y = 4'd4; bus.req_dest_l = 2'd3; bus.req_len = 8'd1;
        bus.grnt_req_vld = 1'b1;
        bus.req_vld = 1'b1;
        @(negedge clk);
        check("prio_grnt_rdy", bus.grnt_req_rdy, 1'b1);
        check("prio_req_blocked", bus.req_rdy, 1'b0);
        @(posedge clk);
        #1;
        bus.grnt_req_vld = 1'b0;
        wait_rdy(0, "prio_request_handshake");
        bus.req_vld = 1'b0;
        bus.pl_vld = 1'b1;
        bus.pl_data = 32'h5A5A0001;
        wait_rdy(2, "prio_payload_handshake");
        bus.pl_vld = 1'b0;
        drain();
        check("prio_head_after_headtail", head_cyc - ht_cyc, 1);

        send_pkt(7, 2, 1, 4, 1'b0, 0, 1'b1);
        drain();
        check("stall_pkt_span", tail_cyc - head_cyc, 9);

        exp_q.push_back({HEAD, head_word(9, 3, 0, 0)});
        exp_q.push_back({TAIL, FLIT_DATA_SIZE'(32'hC0DE)});
        bus.req_dest_x = 4'd9; bus.req_dest_y = 4'd3; bus.req_dest_l = 2'd0; bus.req_len = 8'd0;
        bus.req_vld = 1'b1;
        wait_rdy(0, "len0_request_handshake");
        bus.req_vld = 1'b0;
        set_grant(3, 3, 2, 2, 2, 2);
        bus.grnt_req_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("len0_grant_blocked", bus.grnt_req_rdy, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.pl_vld = 1'b1;
        bus.pl_data = 32'hC0DE;
        wait_rdy(2, "len0_payload_handshake");
        bus.pl_vld = 1'b0;
        wait_rdy(1, "len0_grant_handshake");
        bus.grnt_req_vld = 1'b0;
        drain();
        check("len0_grant_after_tail", ht_cyc - tail_cyc, 1);

        exp_q.push_back({HEAD, head_word(5, 6, 1, 0)});
        exp_q.push_back({BODY, FLIT_DATA_SIZE'(32'h11)});
        bus.req_dest_x = 4'd5; bus.req_dest_y = 4'd6; bus.req_dest_l = 2'd1; bus.req_len = 8'd3;
        bus.req_vld = 1'b1;
        wait_rdy(0, "rst_request_handshake");
        bus.req_vld = 1'b0;
        bus.pl_vld = 1'b1;
        bus.pl_data = 32'h11;
        wait_rdy(2, "rst_payload1_handshake");
        bus.pl_data = 32'h22;
        wait_rdy(2, "rst_payload2_handshake");
        rst = 1'b1;
        bus.pl_vld = 1'b0;
        #1;
        check("midpkt_rst_buf_wen", bus.buf_wen, 1'b0);
        check("midpkt_rst_pl_rdy", bus.pl_rdy, 1'b0);
        check("midpkt_rst_pkt_cnt", pkt_cnt, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_idle_req_rdy", bus.req_rdy, 1'b1);
        check("after_rst_pl_rdy", bus.pl_rdy, 1'b0);
        @(posedge clk);
        #1;
        send_pkt(1, 1, 1, 2, 1'b0, -1, 1'b0);
        drain();

        bp_en = 1'b1;
        repeat (40) begin
            if ($urandom_range(0, 3) == 0)
                do_grant($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                         $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
            else
                send_pkt($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                         $urandom_range(0, 6), 1'b1, -1, 1'b0);
        end
        drain();
        bp_en = 1'b0;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
